// File: rtl/retire_monitor.sv
// ============================================================================
// Module   : retire_monitor
// Purpose  : End-of-test monitor placed after a 5-stage pipeline top. Watches
//            the decode-stage PC and the memory-stage store bus and decides
//            pass / fail / timeout. It also counts cycles and stores, and it
//            raises a sticky done flag.
// Ports    :
//   clk           in   1      system clock, rising edge
//   rst           in   1      synchronous active-high reset
//   pcd           in   32     decode-stage PC
//   mem_write_m   in   1      memory-stage store enable
//   alu_result_m  in   32     memory-stage store address
//   write_data_m  in   32     memory-stage store data
//   done          out  1      sticky, test finished
//   pass          out  1      sticky, valid when done=1
//   fail          out  1      sticky, fail store / wrong pass data / halt
//                             without a pass store
//   timeout       out  1      sticky, TIMEOUT_CYCLES elapsed in RUN
//   cycle_count   out  CNT_W  cycles spent in RUN and SETTLE
//   store_count   out  CNT_W  stores observed before DONE (saturating)
//   signature     out  32     rolling store signature
// Options  : define RETIRE_MONITOR_STORE_SIG_EN to build the signature
//            register. Without it, signature is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retire_monitor #(
  parameter logic [31:0] HALT_PC        = 32'd292,
  parameter int          SETTLE_CYCLES  = 2,
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] FAIL_ADDR      = 32'd96,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcd,
  input  logic             mem_write_m,
  input  logic [31:0]      alu_result_m,
  input  logic [31:0]      write_data_m,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] store_count,
  output logic [31:0]      signature
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int              SET_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [SET_W-1:0] r_settle;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_stores;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;

  logic w_active;
  logic w_store;
  logic w_fail_store;
  logic w_pass_store;
  logic w_halt;
  logic w_settle_end;
  logic w_timeout;

  // Stores are evaluated only while the test is still running.
  assign w_active = (r_state == ST_RUN) || (r_state == ST_SETTLE);
  assign w_store  = w_active && mem_write_m;

  assign w_fail_store = w_store &&
                        ((alu_result_m == FAIL_ADDR) ||
                         ((alu_result_m == PASS_ADDR) && (write_data_m != PASS_DATA)));
  assign w_pass_store = w_store && !w_fail_store &&
                        (alu_result_m == PASS_ADDR) && (write_data_m == PASS_DATA);

  // Halt is recognised only in RUN. Once in SETTLE, the PC is ignored.
  assign w_halt       = (r_state == ST_RUN) && (pcd == HALT_PC);
  assign w_settle_end = (r_state == ST_SETTLE) && (r_settle == SETTLE_LAST);
  assign w_timeout    = (r_state == ST_RUN) && (r_cycle == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_settle  <= '0;
      r_cycle   <= '0;
      r_stores  <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_active) begin
      if (w_store && (r_stores != CNT_MAX)) begin
        r_stores <= r_stores + CNT_ONE;
      end
      // Priority: fail store > pass store > halt > settle end / timeout.
      // The cycle counter does not advance on the edge that enters DONE.
      if (w_fail_store) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
        r_fail  <= 1'b1;
      end else if (w_pass_store) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
        r_pass  <= 1'b1;
      end else if (w_halt) begin
        r_state  <= ST_SETTLE;
        r_settle <= '0;
        r_cycle  <= r_cycle + CNT_ONE;
      end else if (w_settle_end) begin
        // A pass store retires the test on the spot. Reaching the end of
        // SETTLE therefore means that no pass store was ever seen.
        r_state <= ST_DONE;
        r_done  <= 1'b1;
        r_fail  <= 1'b1;
      end else if (w_timeout) begin
        r_state   <= ST_DONE;
        r_done    <= 1'b1;
        r_timeout <= 1'b1;
      end else begin
        r_cycle <= r_cycle + CNT_ONE;
        if (r_state == ST_SETTLE) begin
          r_settle <= r_settle + SETTLE_ONE;
        end
      end
    end else if (r_state != ST_DONE) begin
      // An unused encoding falls back to RUN.
      r_state <= ST_RUN;
    end
  end

`ifdef RETIRE_MONITOR_STORE_SIG_EN
  logic [31:0] r_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= 32'd0;
    end else if (w_store) begin
      r_sig <= {r_sig[30:0], r_sig[31]} ^ alu_result_m ^ write_data_m;
    end
  end

  assign signature = r_sig;
`else
  assign signature = 32'd0;
`endif

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle;
  assign store_count = r_stores;

endmodule

`default_nettype wire
